mmio_bus_master: RTL and testbench

MMIO_BUS_MASTER -- requirements
Module: mmio_bus_master

---
 rtl/mmio_master_pkg.sv | 22 ++
 rtl/mmio_cmd_fifo.sv | 60 ++++++
 rtl/mmio_bus_master.sv | 124 ++++++++++++
 tb/tb_mmio_bus_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_master_pkg.sv
// Shared types for the MMIO bus master: FSM state encoding and the queued command layout.
package mmio_master_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // One queued host command, stored whole in the command FIFO.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/mmio_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count and show-ahead head output.
module mmio_cmd_fifo #(
  parameter int DEPTH_BIT = 2,
  parameter int WIDTH     = 54
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT-1:0] PTR_ONE = DEPTH_BIT'(1);
  localparam logic [DEPTH_BIT:0]   CNT_ONE = (DEPTH_BIT + 1)'(1);
  localparam logic [DEPTH_BIT:0]   CNT_MAX = (DEPTH_BIT + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_BIT-1:0] wr_ptr;
  logic [DEPTH_BIT-1:0] rd_ptr;
  logic [DEPTH_BIT:0]   count;
  logic                 do_push;
  logic                 do_pop;

  // Full/empty come straight from the registered count, so a pop in the
  // same cycle never opens room for a push that was offered while full.
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^DEPTH_BIT.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the storage array is deliberately not reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_bus_master.sv
// Queues host commands and replays each as a single-cycle FPro bus access, returning one response per command.
module mmio_bus_master
  import mmio_master_pkg::*;
#(
  parameter int FIFO_DEPTH_BIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data
);

  state_t state;
  state_t state_next;
  cmd_t   push_cmd;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;
  logic   capture_rsp;

  assign push_cmd = '{wr: cmd_wr, addr: cmd_addr, data: cmd_wr_data};

  // cmd_ready is held low while reset is asserted and rises once it is released.
  assign cmd_ready = !fifo_full && !reset;
  assign rsp_valid = (state == RESP);
  assign busy      = !fifo_empty || (state != IDLE);

  mmio_cmd_fifo #(
    .DEPTH_BIT (FIFO_DEPTH_BIT),
    .WIDTH     (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic: pop into ACCESS from IDLE, or straight from RESP once the response is taken.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    fifo_pop    = 1'b0;
    capture_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        capture_rsp = 1'b1;
        state_next  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ACCESS;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bus registers: strobes are high only in the cycle after a pop; address/data hold between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
    end else begin
      mmio_cs <= fifo_pop;
      mmio_wr <= fifo_pop && head.wr;
      mmio_rd <= fifo_pop && !head.wr;
      if (fifo_pop) begin
        mmio_addr    <= head.addr;
        mmio_wr_data <= head.data;
      end
    end
  end

  // Response registers: captured at the edge that ends ACCESS and held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_wr   <= 1'b0;
      rsp_data <= '0;
    end else if (capture_rsp) begin
      rsp_wr   <= mmio_wr;
      rsp_data <= mmio_wr ? mmio_wr_data : mmio_rd_data;
    end
  end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Self-checking bench: directed latency/backpressure/reset cases plus randomized traffic against a queue model.
module tb_mmio_bus_master;
  import mmio_master_pkg::*;

  localparam int DEPTH_BIT = 2;
  localparam int DEPTH     = 1 << DEPTH_BIT;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [20:0] cmd_addr;
  logic [31:0] cmd_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_data;
  logic        busy;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Peripheral stub: fixed value for slot 3 reg 0, address hash elsewhere, junk outside a read strobe.
  function automatic logic [31:0] stub_val(input logic [20:0] a);
    if (a == 21'h060) return 32'h0000_00F0;
    return {a[10:0], a} ^ 32'h1357_9BDF;
  endfunction

  assign mmio_rd_data = mmio_rd ? stub_val(mmio_addr) : 32'hDEAD_BEEF;

  mmio_bus_master #(.FIFO_DEPTH_BIT(DEPTH_BIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wr_data  (cmd_wr_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_wr       (rsp_wr),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (mmio_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted-but-not-issued commands, and issued-but-not-taken responses.
  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } rsp_t;

  cmd_t        bus_q[$];
  rsp_t        rsp_q[$];
  cmd_t        mon_c;
  logic [20:0] last_addr = '0;

  // Scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      bus_q.delete();
      rsp_q.delete();
      last_addr = '0;
    end else begin
      if (rsp_q.size() != 0) begin
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_wr", rsp_wr, rsp_q[0].wr);
        check("rsp_data", rsp_data, rsp_q[0].data);
      end else begin
        check("rsp_idle", rsp_valid, 1'b0);
      end
      if (mmio_cs) begin
        if (bus_q.size() == 0) begin
          check("cs_no_cmd", mmio_cs, 1'b0);
        end else begin
          mon_c = bus_q.pop_front();
          check("bus_wr", mmio_wr, mon_c.wr);
          check("bus_rd", mmio_rd, !mon_c.wr);
          check("bus_addr", mmio_addr, mon_c.addr);
          if (mon_c.wr) check("bus_wdata", mmio_wr_data, mon_c.data);
          rsp_q.push_back('{wr: mon_c.wr, data: (mon_c.wr ? mon_c.data : stub_val(mon_c.addr))});
          last_addr = mon_c.addr;
        end
      end else begin
        check("strobes_idle", {mmio_wr, mmio_rd}, 2'b00);
        check("addr_hold", mmio_addr, last_addr);
      end
      check("busy", busy, (bus_q.size() != 0) || (rsp_q.size() != 0));
      check("cmd_ready", cmd_ready, bus_q.size() < DEPTH);
      if (cmd_valid && cmd_ready) bus_q.push_back('{wr: cmd_wr, addr: cmd_addr, data: cmd_wr_data});
      if (rsp_valid && rsp_ready && rsp_q.size() != 0) void'(rsp_q.pop_front());
    end
  end

  // Offer one command until accepted or the budget runs out; returns at posedge+1.
  task automatic offer(input logic wr, input logic [20:0] addr, input logic [31:0] data,
                       input int max_cyc, output bit ok);
    ok          = 1'b0;
    cmd_wr      = wr;
    cmd_addr    = addr;
    cmd_wr_data = data;
    cmd_valid   = 1'b1;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check("wait_rsp", seen, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit idle = 1'b0;
    for (int i = 0; i < max_cyc && !idle; i++) begin
      @(negedge clk);
      idle = !busy && !rsp_valid;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_model", bus_q.size() + rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Park the FSM in RESP with one response pending, then queue n more commands.
  task automatic park_fill(input int n);
    bit ok;
    rsp_ready = 1'b0;
    offer(1'($urandom), 21'($urandom), $urandom, 4, ok);
    check("park_primer", ok, 1'b1);
    wait_rsp(8);
    for (int k = 0; k < n; k++) begin
      offer(1'($urandom), 21'($urandom), $urandom, 2, ok);
      check("fill_accept", ok, 1'b1);
    end
  endtask

  // Single command with rsp_ready high: ACCESS in T+2, response in T+3.
  task automatic do_single(input logic wr, input logic [20:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rsp);
    cmd_wr      = wr;
    cmd_addr    = addr;
    cmd_wr_data = data;
    cmd_valid   = 1'b1;
    @(negedge clk);
    check("s_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("s_t1_cs", mmio_cs, 1'b0);
    @(negedge clk);
    check("s_t2_cs", mmio_cs, 1'b1);
    check("s_t2_wr", mmio_wr, wr);
    check("s_t2_rd", mmio_rd, !wr);
    check("s_t2_addr", mmio_addr, addr);
    if (wr) check("s_t2_wdata", mmio_wr_data, data);
    @(negedge clk);
    check("s_t3_valid", rsp_valid, 1'b1);
    check("s_t3_wr", rsp_wr, wr);
    check("s_t3_data", rsp_data, exp_rsp);
    check("s_t3_cs", mmio_cs, 1'b0);
    @(negedge clk);
    check("s_t4_valid", rsp_valid, 1'b0);
    check("s_t4_busy", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         ok;
    bit         acc;
    logic [8:0] seen_cs;

    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = '0;
    cmd_wr_data = '0;
    rsp_ready   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_strobes", {mmio_cs, mmio_wr, mmio_rd}, 3'b000);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_addr", mmio_addr, 21'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", cmd_ready, 1'b1);

    // Write slot 2 reg 0, then read slot 3 reg 0.
    rsp_ready = 1'b1;
    do_single(1'b1, 21'h040, 32'h0000_00A5, 32'h0000_00A5);
    do_single(1'b0, 21'h060, 32'h1234_5678, 32'h0000_00F0);
    do_single(1'b1, 21'h1F_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Back-to-back throughput: one access every two cycles.
    park_fill(4);
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      seen_cs[8-i] = mmio_cs;
    end
    check("throughput", seen_cs, 9'b101010100);
    @(posedge clk);
    #1;

    // Full FIFO: fifth command blocked while the response is held, then released.
    park_fill(4);
    cmd_wr      = 1'b0;
    cmd_addr    = 21'h0A5_5A5;
    cmd_wr_data = 32'hCAFE_F00D;
    cmd_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_block", cmd_ready, 1'b0);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_quiet", mmio_cs, 1'b0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("full_at_pop", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("next_access", mmio_cs, 1'b1);
    check("ready_after_pop", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle(40);

    // Randomized traffic with random backpressure.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (!cmd_valid || acc) begin
        cmd_valid   = ($urandom_range(0, 99) < 60);
        cmd_wr      = 1'($urandom);
        cmd_addr    = 21'($urandom);
        cmd_wr_data = $urandom;
      end
      rsp_ready = ($urandom_range(0, 99) < 55);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(60);

    // Reset in the middle of ACCESS with three commands still queued.
    park_fill(4);
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_access", mmio_cs, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_strobes", {mmio_cs, mmio_wr, mmio_rd}, 3'b000);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_cs", mmio_cs, 1'b0);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_valid", rsp_valid, 1'b0);
      check("post_rst_ready", cmd_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    do_single(1'b0, 21'h060, 32'h0, 32'h0000_00F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
